// File: rtl/lzc_run_encoder.sv
// Run-length encoder, the inverse of the leading-zero counter: cnt_i fill bits,
// one marker bit, then payload MSB-first; payload bits that fall off set sticky_o.
module lzc_run_encoder #(
  parameter int WIDTH = 31,
  parameter bit MODE  = 1'b1,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [CW-1:0]    cnt_i,
  input  logic             empty_i,
  input  logic [WIDTH-1:0] payload_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             sticky_o,
  output logic             sat_o
);

  localparam bit MARK = MODE;
  localparam bit FILL = ~MODE;

  // Handshake: a beat moves into a stage when that stage is empty or its
  // contents move on in the same cycle; input transfers on valid_i & ready_o,
  // output transfers on valid_o & ready_i.
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  assign s2_adv  = !s2_valid | ready_i;
  assign s1_adv  = !s1_valid | s2_adv;
  assign ready_o = s1_adv & !rst_i;

  // Right shift that brings fill bits in from the top.
  function automatic logic [WIDTH-1:0] fill_shift(input logic [WIDTH-1:0] x,
                                                  input logic [CW-1:0]    sh);
    logic [WIDTH-1:0] ones;
    ones = '1;
    fill_shift = (x >> sh) | (FILL ? ~(ones >> sh) : '0);
  endfunction

  // Stage 1: coarse shift by the multiple-of-8 part of cnt_i.
  // payload_i[0] never reaches data_o, so the data path starts W bits wide.
  logic [CW-1:0]    k8;
  logic [WIDTH-1:0] dword;
  logic             lo_sticky_d;

  assign k8    = {cnt_i[CW-1:3], 3'b000};
  assign dword = {MARK, payload_i[WIDTH-1:1]};

  always_comb begin
    lo_sticky_d = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      if (j < int'(k8)) lo_sticky_d = lo_sticky_d | payload_i[j];
    end
  end

  logic [WIDTH-1:0] s1_coarse;
  logic [WIDTH-1:0] s1_pay;
  logic             s1_lo_sticky;
  logic [2:0]       s1_fine;
  logic             s1_empty;
  logic             s1_sat;

  // Stage 2: fine shift (0-7) and the payload bits it pushes out of the window.
  logic [WIDTH-1:0] data_d;
  logic             hi_sticky_d;
  logic             sticky_d;

  always_comb begin
    hi_sticky_d = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      if (j <= int'(s1_fine)) hi_sticky_d = hi_sticky_d | s1_pay[j];
    end
    data_d   = s1_empty ? {WIDTH{FILL}}
                        : fill_shift(s1_coarse, {{(CW-3){1'b0}}, s1_fine});
    sticky_d = !s1_empty & (s1_lo_sticky | hi_sticky_d);
  end

  logic [WIDTH-1:0] s2_data;
  logic             s2_sticky;
  logic             s2_sat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid     <= 1'b0;
      s1_coarse    <= '0;
      s1_pay       <= '0;
      s1_lo_sticky <= 1'b0;
      s1_fine      <= '0;
      s1_empty     <= 1'b0;
      s1_sat       <= 1'b0;
      s2_valid     <= 1'b0;
      s2_data      <= '0;
      s2_sticky    <= 1'b0;
      s2_sat       <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= valid_i;
        if (valid_i) begin
          s1_coarse    <= fill_shift(dword, k8);
          s1_pay       <= payload_i >> k8;
          s1_lo_sticky <= lo_sticky_d;
          s1_fine      <= cnt_i[2:0];
          s1_empty     <= empty_i;
          s1_sat       <= (cnt_i >= CW'(WIDTH)) & !empty_i;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data   <= data_d;
          s2_sticky <= sticky_d;
          s2_sat    <= s1_sat;
        end
      end
    end
  end

  assign valid_o  = s2_valid;
  assign data_o   = s2_data;
  assign sticky_o = s2_sticky;
  assign sat_o    = s2_sat;

endmodule

// File: tb/tb_lzc_run_encoder.sv
// Bench for lzc_run_encoder: WIDTH=8 vector table, backpressure and reset
// sequences, then randomized WIDTH=31 traffic against a bit-sequence model.
module tb_lzc_run_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- shared stimulus, per-instance gating ----------------
  logic        valid_i, ready_i, empty;
  logic [4:0]  cnt;
  logic [30:0] pay;
  logic        grp31, mode_sel;

  logic v8m1, v8m0, v31m1, v31m0;
  assign v8m1  = valid_i & !grp31 &  mode_sel;
  assign v8m0  = valid_i & !grp31 & !mode_sel;
  assign v31m1 = valid_i &  grp31 &  mode_sel;
  assign v31m0 = valid_i &  grp31 & !mode_sel;

  logic ro8m1, ro8m0, ro31m1, ro31m0;
  logic vo8m1, vo8m0, vo31m1, vo31m0;
  logic st8m1, st8m0, st31m1, st31m0;
  logic sa8m1, sa8m0, sa31m1, sa31m0;
  logic [7:0]  d8m1, d8m0;
  logic [30:0] d31m1, d31m0;

  lzc_run_encoder #(.WIDTH(8), .MODE(1'b1)) u8m1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v8m1), .ready_o(ro8m1), .cnt_i(cnt[3:0]),
    .empty_i(empty), .payload_i(pay[7:0]), .valid_o(vo8m1), .ready_i(ready_i),
    .data_o(d8m1), .sticky_o(st8m1), .sat_o(sa8m1));
  lzc_run_encoder #(.WIDTH(8), .MODE(1'b0)) u8m0 (
    .clk_i(clk), .rst_i(rst), .valid_i(v8m0), .ready_o(ro8m0), .cnt_i(cnt[3:0]),
    .empty_i(empty), .payload_i(pay[7:0]), .valid_o(vo8m0), .ready_i(ready_i),
    .data_o(d8m0), .sticky_o(st8m0), .sat_o(sa8m0));
  lzc_run_encoder #(.WIDTH(31), .MODE(1'b1)) u31m1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v31m1), .ready_o(ro31m1), .cnt_i(cnt),
    .empty_i(empty), .payload_i(pay), .valid_o(vo31m1), .ready_i(ready_i),
    .data_o(d31m1), .sticky_o(st31m1), .sat_o(sa31m1));
  lzc_run_encoder #(.WIDTH(31), .MODE(1'b0)) u31m0 (
    .clk_i(clk), .rst_i(rst), .valid_i(v31m0), .ready_o(ro31m0), .cnt_i(cnt),
    .empty_i(empty), .payload_i(pay), .valid_o(vo31m0), .ready_i(ready_i),
    .data_o(d31m0), .sticky_o(st31m0), .sat_o(sa31m0));

  logic        ro, vo, st, sa;
  logic [30:0] dat;
  always_comb begin
    ro = ro8m0; vo = vo8m0; st = st8m0; sa = sa8m0; dat = {23'b0, d8m0};
    case ({grp31, mode_sel})
      2'b01: begin ro = ro8m1;  vo = vo8m1;  st = st8m1;  sa = sa8m1;  dat = {23'b0, d8m1}; end
      2'b10: begin ro = ro31m0; vo = vo31m0; st = st31m0; sa = sa31m0; dat = d31m0; end
      2'b11: begin ro = ro31m1; vo = vo31m1; st = st31m1; sa = sa31m1; dat = d31m1; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [30:0] data;
    logic        sticky;
    logic        sat;
  } res_t;

  // Reference: lay the word out as an explicit bit sequence (fill run, marker,
  // payload MSB-first); the first w bits are the word, the rest are dropped.
  function automatic res_t model(input int w, input bit mode, input int c,
                                 input bit emp, input logic [30:0] p);
    bit   seq[$];
    bit   is_pay[$];
    res_t r;
    r = '0;
    if (emp) begin
      for (int i = 0; i < w; i++) r.data[i] = !mode;
      return r;
    end
    r.sat = (c >= w);
    for (int i = 0; i < c; i++) begin seq.push_back(!mode); is_pay.push_back(1'b0); end
    seq.push_back(mode); is_pay.push_back(1'b0);
    for (int i = w - 1; i >= 0; i--) begin seq.push_back(p[i]); is_pay.push_back(1'b1); end
    for (int i = 0; i < seq.size(); i++) begin
      if (i < w) r.data[w-1-i] = seq[i];
      else if (is_pay[i] && seq[i]) r.sticky = 1'b1;
    end
    return r;
  endfunction

  function automatic int lead_zeros(input logic [30:0] d);
    int  n;
    bit  found;
    n = 0; found = 1'b0;
    for (int i = 30; i >= 0; i--) begin
      if (!found) begin
        if (d[i]) found = 1'b1;
        else n++;
      end
    end
    return n;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit         mode;
    int         c;
    bit         emp;
    logic [7:0] p;
    logic [7:0] exp_d;
    bit         exp_s;
    bit         exp_sat;
  } vec_t;

  vec_t vt[12];

  // ---------------- driver tasks ----------------
  task automatic send8(input vec_t v);
    @(negedge clk);
    grp31 = 1'b0; mode_sel = v.mode; ready_i = 1'b1;
    valid_i = 1'b1; cnt = 5'(v.c); empty = v.emp; pay = {23'b0, v.p};
    #1 chk("vec_ready", 32'(ro), 32'd1);
    @(negedge clk);
    valid_i = 1'b0;
    chk("vec_lat1", 32'(vo), 32'd0);
    @(negedge clk);
    chk("vec_valid", 32'(vo), 32'd1);
    chk("vec_data", 32'(dat), 32'(v.exp_d));
    chk("vec_sticky", 32'(st), 32'(v.exp_s));
    chk("vec_sat", 32'(sa), 32'(v.exp_sat));
  endtask

  task automatic backpressure();
    res_t        exp[6];
    logic [3:0]  bc[6];
    logic [7:0]  bp[6];
    logic [32:0] hold;
    bit          have_hold, saw_full;
    int          k, sent, got;
    for (int i = 0; i < 6; i++) begin
      bc[i]  = 4'($urandom_range(0, 9));
      bp[i]  = 8'($urandom);
      exp[i] = model(8, 1'b1, int'(bc[i]), 1'b0, {23'b0, bp[i]});
    end
    grp31 = 1'b0; mode_sel = 1'b1; empty = 1'b0;
    k = 0; sent = 0; got = 0; have_hold = 1'b0; saw_full = 1'b0; hold = '0;
    while (got < 6 && k < 40) begin
      @(negedge clk);
      ready_i = !(k >= 3 && k <= 6);
      valid_i = (sent < 6);
      if (sent < 6) begin cnt = {1'b0, bc[sent]}; pay = {23'b0, bp[sent]}; end
      #1;
      if (have_hold) chk("bp_stable", 32'({dat, st, sa}), 32'(hold));
      if (vo && !ready_i) begin hold = {dat, st, sa}; have_hold = 1'b1; end
      else have_hold = 1'b0;
      if (!ready_i && !ro) saw_full = 1'b1;
      if (vo && ready_i) begin
        chk("bp_data", 32'(dat), 32'(exp[got].data));
        chk("bp_sticky", 32'(st), 32'(exp[got].sticky));
        chk("bp_sat", 32'(sa), 32'(exp[got].sat));
        got++;
      end
      if (valid_i && ro) sent++;
      k++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    chk("bp_full_stall", 32'(saw_full), 32'd1);
    chk("bp_count", 32'(got), 32'd6);
    @(negedge clk);
    chk("bp_no_dup", 32'(vo), 32'd0);
  endtask

  task automatic reset_midstream();
    res_t rc;
    grp31 = 1'b0; mode_sel = 1'b1; empty = 1'b0;
    @(negedge clk);
    ready_i = 1'b0; valid_i = 1'b1; cnt = 5'd1; pay = 31'h000000C3;
    @(negedge clk);
    cnt = 5'd2; pay = 31'h0000005A;
    @(negedge clk);
    cnt = 5'd0; pay = 31'h000000FF; rst = 1'b1;
    #1 chk("mid_inflight", 32'(vo), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(vo), 32'd0);
    chk("mid_rst_data", 32'(dat), 32'd0);
    chk("mid_rst_sticky", 32'(st), 32'd0);
    chk("mid_rst_sat", 32'(sa), 32'd0);
    ready_i = 1'b1; valid_i = 1'b1; cnt = 5'd5; pay = 31'h000000A5;
    rc = model(8, 1'b1, 5, 1'b0, 31'h000000A5);
    @(negedge clk);
    valid_i = 1'b0;
    chk("mid_lat1", 32'(vo), 32'd0);
    @(negedge clk);
    chk("mid_valid", 32'(vo), 32'd1);
    chk("mid_data", 32'(dat), 32'(rc.data));
    chk("mid_sticky", 32'(st), 32'(rc.sticky));
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_ghost", 32'(vo), 32'd0);
    end
  endtask

  task automatic run_random(input bit mode, input int n);
    logic [32:0] exp_q[$];
    logic [5:0]  info_q[$];
    logic [32:0] e;
    logic [5:0]  inf;
    int          accepted, cycles;
    grp31 = 1'b1; mode_sel = mode;
    accepted = 0; cycles = 0;
    while ((accepted < n || exp_q.size() > 0) && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      ready_i = ($urandom_range(0, 9) < 7);
      valid_i = (accepted < n) && ($urandom_range(0, 9) < 8);
      cnt     = 5'($urandom_range(0, 31));
      empty   = ($urandom_range(0, 15) == 0);
      pay     = 31'($urandom);
      #1;
      if (vo && ready_i) begin
        if (exp_q.size() == 0) chk("r_spurious", 32'd1, 32'd0);
        else begin
          e   = exp_q.pop_front();
          inf = info_q.pop_front();
          chk("r_data", 32'(dat), 32'(e[32:2]));
          chk("r_sticky", 32'(st), 32'(e[1]));
          chk("r_sat", 32'(sa), 32'(e[0]));
          if (mode && !inf[5] && inf[4:0] < 5'd31) begin
            chk("r_lzc_cnt", 32'(lead_zeros(dat)), 32'(inf[4:0]));
            chk("r_lzc_nonempty", 32'(dat != 31'd0), 32'd1);
          end
        end
      end
      if (valid_i && ro) begin
        exp_q.push_back(model(31, mode, int'(cnt), empty, pay));
        info_q.push_back({empty, cnt});
        accepted++;
      end
    end
    valid_i = 1'b0; ready_i = 1'b1;
    chk("r_accepted", 32'(accepted), 32'(n));
    chk("r_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vt[0]  = '{1'b1, 2,  1'b0, 8'hB6, 8'h36, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 0,  1'b0, 8'hFE, 8'hFF, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 8,  1'b0, 8'h01, 8'h00, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 3,  1'b0, 8'h00, 8'hE0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 5,  1'b1, 8'hAA, 8'hFF, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 3,  1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 15, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 7,  1'b0, 8'hFF, 8'h01, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1,  1'b0, 8'h80, 8'hA0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 4,  1'b0, 8'h0F, 8'h08, 1'b1, 1'b0};
    vt[10] = '{1'b0, 9,  1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1};
    vt[11] = '{1'b1, 1,  1'b0, 8'h81, 8'h60, 1'b1, 1'b0};

    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; empty = 1'b0;
    cnt = '0; pay = '0; grp31 = 1'b0; mode_sel = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready_low", 32'(ro), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      for (int m = 0; m < 2; m++) begin
        grp31 = g[0]; mode_sel = m[0];
        #1;
        chk("reset_valid", 32'(vo), 32'd0);
        chk("reset_data", 32'(dat), 32'd0);
        chk("reset_sticky", 32'(st), 32'd0);
        chk("reset_sat", 32'(sa), 32'd0);
        chk("reset_ready_high", 32'(ro), 32'd1);
      end
    end

    for (int i = 0; i < 12; i++) send8(vt[i]);
    backpressure();
    reset_midstream();
    run_random(1'b1, 5000);
    run_random(1'b0, 5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
